inv_ne_lshr_search_ctrl: RTL and testbench
==========================================

# inv_ne_lshr_search_ctrl

Sequential controller that resolves the invertibility query "find x such that (s >> x) != t" for WIDTH-bit logical right shift. It first checks a candidate x supplied by the combinational Skolem function block. If that candidate fails, it falls back to an exhaustive search over all shift amounts. It sits between the query producer and the Skolem datapath, validating every Skolem answer before it is released, and it reports when no witness exists.

## Interface

Parameters:
- WIDTH, default 4: bit width of s, t and x.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- req_valid  input  1  a query is offered.
- req_ready  output  1  controller can accept a query; high only in IDLE.
- s  input  WIDTH  shifted operand; sampled on request handshake.
- t  input  WIDTH  value the result must differ from; sampled on request handshake.
- sk_x  input  WIDTH  candidate from the Skolem function block; sampled on request handshake.
- rsp_valid  output  1  response is available.
- rsp_ready  input  1  consumer accepts the response.
- rsp_x  output  WIDTH  witness shift amount; 0 when rsp_found=0.
- rsp_found  output  1  a witness exists.
- rsp_src  output  1  1 = Skolem candidate accepted; 0 = witness came from search or none exists.
- rsp_tries  output  WIDTH+1  number of candidates evaluated, counting the Skolem check.

## Operation

- Predicate P(x) = ((s >> x) != t), where x is the full WIDTH-bit amount.
  - Logical shift, zero-fill.
  - Any x >= WIDTH gives 0.
  - There is one shared evaluator; exactly one P evaluation per cycle in CHECK or SEARCH.
- States: IDLE, CHECK, SEARCH, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: latch s, t, sk_x; go to CHECK.
- CHECK: evaluate P(sk_x); tries=1.
  - If true: rsp_x=sk_x, found=1, src=1; go to RESP.
  - Else: cnt=0; go to SEARCH.
- SEARCH: evaluate P(cnt); tries increments each cycle.
  - If true: rsp_x=cnt, found=1, src=0; go to RESP.
  - Else if cnt == 2^WIDTH-1: rsp_x=0, found=0, src=0; go to RESP.
  - Else: cnt++.
  - The search is exhaustive with no early cut at WIDTH, so cycle counts are deterministic per input.
- RESP:
  - rsp_valid=1.
  - All rsp_* outputs held stable until rsp_valid && rsp_ready.
  - On that handshake: go to IDLE.
- req_ready=0 in CHECK, SEARCH and RESP. req_valid is ignored there and nothing is latched.
- Arithmetic:
  - cnt is WIDTH bits and never wraps; the terminal check happens before increment.
  - rsp_tries maximum is 2^WIDTH+1, which fits in WIDTH+1 bits.
- A witness fails to exist only when s=0 and t=0. A found=0 response for any other input is a bug.

## Timing

- Reset values, applied immediately on rst_n low:
  - state=IDLE, req_ready=1.
  - rsp_valid=0, rsp_x=0, rsp_found=0, rsp_src=0, rsp_tries=0.
  - cnt=0.
- Reset mid-operation aborts the query. No response is produced, and the query is not replayed.
- Taking request handshake at edge k:
  - CHECK occupies cycle k+1.
  - Skolem candidate accepted: rsp_valid high from cycle k+2.
  - Search witness at cnt=n: rsp_valid high from cycle k+3+n.
  - No witness: rsp_valid high from cycle k+2+2^WIDTH.
- The response handshake at edge m returns to IDLE, with req_ready=1 in cycle m+1. There is no same-cycle response-to-request bypass, so back-to-back throughput is one query per (latency+1) cycles minimum.
- rsp_ready is ignored outside RESP.
- rsp_* outputs are registered. Their values outside RESP are don't-care, but must not change while rsp_valid=1.

## Test plan

- s=0x8, t=0x4, sk_x=0, handshake at k:
  - rsp_valid at k+2.
  - Response: rsp_x=0, found=1, src=1, tries=1.
- s=0x8, t=0x8, sk_x=0:
  - The candidate fails; search cnt=0 fails and cnt=1 passes.
  - Response: rsp_x=1, found=1, src=0, tries=3, rsp_valid at k+4.
- s=0x0, t=0x0, sk_x=3:
  - Response: found=0, rsp_x=0, src=0, tries=17, rsp_valid at k+18.
- s=0x0, t=0x1, sk_x=5 (amount >= WIDTH):
  - 0 != 1, so the candidate is accepted.
  - Response: rsp_x=5, src=1, tries=1.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP while toggling req_valid.
  - rsp_* outputs stay constant and req_ready stays 0.
  - No new query is latched.
  - After rsp_ready=1, req_ready=1 on the next cycle.
- Reset mid-search: rst_n low during SEARCH of the s=0, t=0 query.
  - rsp_valid=0 and req_ready=1 immediately.
  - After release, the query s=0x8, t=0x4, sk_x=0 completes exactly as in the first scenario.

Source files
------------

// File: rtl/inv_ne_lshr_search_ctrl.sv
// Invertibility controller for (s >> x) != t: validates a Skolem candidate, then
// falls back to an exhaustive scan over every WIDTH-bit shift amount.
module inv_ne_lshr_search_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [WIDTH-1:0] s_i,
  input  logic [WIDTH-1:0] t_i,
  input  logic [WIDTH-1:0] sk_x_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_x_o,
  output logic             rsp_found_o,
  output logic             rsp_src_o,
  output logic [WIDTH:0]   rsp_tries_o
);

  typedef enum logic [1:0] {StIdle, StCheck, StSearch, StResp} state_e;

  localparam logic [WIDTH-1:0] CntMax   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CntOne   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   TriesOne = {{WIDTH{1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] t_q, t_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rsp_x_q, rsp_x_d;
  logic             found_q, found_d;
  logic             src_q, src_d;
  logic [WIDTH:0]   tries_q, tries_d;

  logic [WIDTH-1:0] eval_x;
  logic             hit;

  // Single shared evaluator; shift amounts >= WIDTH naturally yield zero.
  always_comb begin
    eval_x = (state_q == StCheck) ? cand_q : cnt_q;
    hit    = ((s_q >> eval_x) != t_q);
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    t_d     = t_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    rsp_x_d = rsp_x_q;
    found_d = found_q;
    src_d   = src_q;
    tries_d = tries_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          s_d     = s_i;
          t_d     = t_i;
          cand_d  = sk_x_i;
          state_d = StCheck;
        end
      end
      StCheck: begin
        tries_d = TriesOne;
        if (hit) begin
          rsp_x_d = cand_q;
          found_d = 1'b1;
          src_d   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d   = '0;
          state_d = StSearch;
        end
      end
      StSearch: begin
        tries_d = tries_q + TriesOne;
        if (hit) begin
          rsp_x_d = cnt_q;
          found_d = 1'b1;
          src_d   = 1'b0;
          state_d = StResp;
        end else if (cnt_q == CntMax) begin
          // Terminal check precedes the increment so cnt never wraps.
          rsp_x_d = '0;
          found_d = 1'b0;
          src_d   = 1'b0;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StResp: begin
        if (rsp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      s_q     <= '0;
      t_q     <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      rsp_x_q <= '0;
      found_q <= 1'b0;
      src_q   <= 1'b0;
      tries_q <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      t_q     <= t_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      rsp_x_q <= rsp_x_d;
      found_q <= found_d;
      src_q   <= src_d;
      tries_q <= tries_d;
    end
  end

  assign req_ready_o = (state_q == StIdle);
  assign rsp_valid_o = (state_q == StResp);
  assign rsp_x_o     = rsp_x_q;
  assign rsp_found_o = found_q;
  assign rsp_src_o   = src_q;
  assign rsp_tries_o = tries_q;

endmodule

// File: tb/tb_inv_ne_lshr_search_ctrl.sv
// Bench for inv_ne_lshr_search_ctrl: directed scenarios plus random queries against
// a search-by-definition reference model.
module tb_inv_ne_lshr_search_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [W-1:0] s = '0;
  logic [W-1:0] t = '0;
  logic [W-1:0] sk_x = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_x;
  logic         rsp_found;
  logic         rsp_src;
  logic [W:0]   rsp_tries;

  int n_checks = 0;
  int n_pass = 0;

  inv_ne_lshr_search_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .s_i         (s),
    .t_i         (t),
    .sk_x_i      (sk_x),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_x_o     (rsp_x),
    .rsp_found_o (rsp_found),
    .rsp_src_o   (rsp_src),
    .rsp_tries_o (rsp_tries)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Behavioural model: the predicate by definition, then witness / tries / latency.
  function automatic bit pred(input int sv, input int tv, input int x);
    int shifted;
    shifted = (x >= W) ? 0 : (sv / (1 << x));
    return shifted != tv;
  endfunction

  function automatic void model(input int sv, input int tv, input int kv, output int ex,
                                output int ef, output int es, output int et, output int el);
    ex = 0; ef = 0; es = 0; et = 1 + (1 << W); el = 2 + (1 << W);
    if (pred(sv, tv, kv)) begin
      ex = kv; ef = 1; es = 1; et = 1; el = 2;
      return;
    end
    for (int n = 0; n < (1 << W); n++) begin
      if (pred(sv, tv, n)) begin
        ex = n; ef = 1; et = n + 2; el = n + 3;
        return;
      end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one query; hold = cycles of rsp_ready=0 backpressure with req_valid toggling.
  task automatic run_query(input int sv, input int tv, input int kv, input int hold,
                           input string tag);
    int ex, ef, es, et, el, lat;
    logic [W-1:0] hx;
    logic hf, hs;
    logic [W:0] ht;
    model(sv, tv, kv, ex, ef, es, et, el);
    chk({tag, ".req_ready_idle"}, req_ready, 1);
    s = sv[W-1:0]; t = tv[W-1:0]; sk_x = kv[W-1:0]; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    chk({tag, ".req_ready_busy"}, req_ready, 0);
    lat = 1;
    while (!rsp_valid && lat < 64) begin
      step();
      lat++;
    end
    chk({tag, ".latency"}, lat, el);
    chk({tag, ".rsp_x"}, rsp_x, ex);
    chk({tag, ".rsp_found"}, rsp_found, ef);
    chk({tag, ".rsp_src"}, rsp_src, es);
    chk({tag, ".rsp_tries"}, rsp_tries, et);
    hx = rsp_x; hf = rsp_found; hs = rsp_src; ht = rsp_tries;
    for (int i = 0; i < hold; i++) begin
      req_valid = ~req_valid;
      s = ~s; t = t + 1; sk_x = sk_x + 3;
      step();
      chk({tag, ".hold_valid"}, rsp_valid, 1);
      chk({tag, ".hold_ready"}, req_ready, 0);
      chk({tag, ".hold_vec"}, {hx, hf, hs, ht}, {rsp_x, rsp_found, rsp_src, rsp_tries});
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk({tag, ".post_rsp_valid"}, rsp_valid, 0);
    chk({tag, ".post_req_ready"}, req_ready, 1);
  endtask

  initial begin
    int sv, tv, kv;
    #2;
    chk("reset.req_ready", req_ready, 1);
    chk("reset.rsp_valid", rsp_valid, 0);
    chk("reset.rsp_vec", {rsp_x, rsp_found, rsp_src, rsp_tries}, 0);
    step();
    rst_n = 1'b1;
    step();

    run_query(8, 4, 0, 0, "skolem_ok");
    run_query(8, 8, 0, 0, "search_n1");
    run_query(0, 0, 3, 0, "no_witness");
    run_query(0, 1, 5, 0, "amt_ge_width");
    run_query(8, 8, 0, 5, "backpressure");
    // A query following the backpressure window must reflect fresh inputs only.
    run_query(8, 4, 0, 0, "after_bp");

    s = 0; t = 0; sk_x = 3; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    chk("midreset.rsp_valid", rsp_valid, 0);
    chk("midreset.req_ready", req_ready, 1);
    step();
    rst_n = 1'b1;
    step();
    chk("midreset.no_replay", rsp_valid, 0);
    run_query(8, 4, 0, 0, "after_reset");

    for (int i = 0; i < 40; i++) begin
      sv = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, (1 << W) - 1));
      tv = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, (1 << W) - 1));
      kv = int'($urandom_range(0, (1 << W) - 1));
      run_query(sv, tv, kv, int'($urandom_range(0, 2)), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
